// File: rtl/rv_imem.sv
// Instruction memory with a byte-stream program loader.
// The core is held in reset while an image is loaded; fetches are combinational in RUN.
module rv_imem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              addr_i,
  output logic [31:0]              instr_o,
  output logic                     fetch_err_o,
  input  logic                     load_start_i,
  input  logic                     load_valid_i,
  input  logic [7:0]               load_data_i,
  input  logic                     load_last_i,
  output logic                     load_ready_o,
  output logic                     core_rst_no,
  output logic [$clog2(DEPTH):0]   words_loaded_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [31:0] FETCH_LIMIT = 32'(4 * DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, LOAD} state_e;

  state_e      state_q, state_d;
  logic [AW:0] ptr_q;
  logic [1:0]  lane_q;
  logic [23:0] buf_q;
  logic        ovf_q;
  logic        accept, word_done, room;
  logic [31:0] word;
  logic [31:0] mem [DEPTH];

  // Partial words are zero-extended, so the assembled word depends only on the current lane.
  always_comb begin
    accept    = (state_q == LOAD) && load_valid_i;
    word_done = accept && ((lane_q == 2'd3) || load_last_i);
    room      = ptr_q < PTR_MAX;
    word      = 32'h0;
    case (lane_q)
      2'd0: word = {24'h0, load_data_i};
      2'd1: word = {16'h0, load_data_i, buf_q[7:0]};
      2'd2: word = {8'h0, load_data_i, buf_q[15:0]};
      default: word = {load_data_i, buf_q[23:0]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:  if (load_start_i) state_d = LOAD;
      LOAD: if (accept && load_last_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      lane_q <= 2'd0;
      buf_q  <= 24'h0;
      ovf_q  <= 1'b0;
    end else if ((state_q == RUN) && load_start_i) begin
      ptr_q  <= '0;
      lane_q <= 2'd0;
      buf_q  <= 24'h0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      case (lane_q)
        2'd0: buf_q[7:0]   <= load_data_i;
        2'd1: buf_q[15:8]  <= load_data_i;
        2'd2: buf_q[23:16] <= load_data_i;
        default: ;
      endcase
      lane_q <= load_last_i ? 2'd0 : lane_q + 2'd1;
      if (word_done) begin
        // Once full, excess words are dropped rather than wrapping over the image.
        if (room) ptr_q <= ptr_q + PTR_ONE;
        else      ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (word_done && room) mem[ptr_q[AW-1:0]] <= word;
  end

  always_comb begin
    fetch_err_o    = (addr_i[1:0] != 2'b00) || (addr_i >= FETCH_LIMIT);
    instr_o        = ((state_q == RUN) && !fetch_err_o) ? mem[addr_i[AW+1:2]] : NOP;
    load_ready_o   = (state_q == LOAD);
    core_rst_no    = (state_q != LOAD);
    words_loaded_o = ptr_q;
    overflow_o     = ovf_q;
  end

endmodule
